axis_width_downsizer: RTL and testbench
=======================================

// Module: axis_width_downsizer
// PURPOSE
//  AXI-Stream width downsizer. Accepts wide beats of S_WORDS words and emits them as
//  R = S_WORDS/M_WORDS narrow beats of M_WORDS words each, lowest-indexed words first.
//  Sits between a wide AXIS source and a narrow AXIS sink (e.g. a 32b producer feeding
//  an 8b consumer). Sustains full throughput with no bubbles across wide-beat boundaries.
// PARAMETERS
//  WORD_W   8  bits per word
//  S_WORDS  4  words per input beat; must be an integer multiple of M_WORDS
//  M_WORDS  1  words per output beat; R = S_WORDS/M_WORDS >= 1
// PORTS
//  clk      in   1                  clock; all state updates on posedge
//  rstn     in   1                  reset, synchronous, active-low
//  s_valid  in   1                  input beat valid
//  s_ready  out  1                  downsizer can accept input beat
//  s_data   in   [S_WORDS][WORD_W]  input beat; word i = s_data[i]
//  m_valid  out  1                  output sub-beat valid
//  m_ready  in   1                  downstream accepts sub-beat
//  m_data   out  [M_WORDS][WORD_W]  output sub-beat
// BEHAVIOUR
//  - State: hold register buf[S_WORDS], flag full, sub-beat counter cnt in 0..R-1
//    (width $clog2(R), min 1 bit).
//  - Reset (rstn=0 at posedge): full=0, cnt=0. Outputs m_valid=0, s_ready=0 while rstn=0.
//    buf contents don't care. Reset mid-operation discards the held beat and any unsent
//    sub-beats. No output beat is emitted after reset until a new input handshake.
//  - Handshakes: a transfer occurs on a posedge where valid && ready. Input handshake at
//    s_valid&&s_ready; output handshake at m_valid&&m_ready.
//  - m_valid = full. m_data = buf[cnt*M_WORDS +: M_WORDS].
//  - s_ready = rstn && (!full || (m_ready && cnt==R-1)). Combinational path from m_ready
//    to s_ready is permitted and required for zero-bubble throughput.
//  - On an output handshake with cnt<R-1: cnt <= cnt+1.
//  - On an output handshake with cnt==R-1: cnt <= 0, and full <= 0 unless an input
//    handshake happens on the same edge.
//  - On an input handshake: buf <= s_data, full <= 1, cnt <= 0. Simultaneous last-sub-beat
//    output and input handshakes: the new beat is loaded and full stays 1.
//  - Latency: the first sub-beat is valid in the cycle after the input handshake.
//  - Throughput: with m_ready=1 and s_valid=1 continuously, exactly one sub-beat per cycle
//    and one input beat every R cycles.
//  - AXIS rules: while m_valid && !m_ready, m_valid and m_data hold stable. m_valid never
//    depends combinationally on m_ready. m_data is don't care while m_valid=0.
//  - Input data is sampled only on an input handshake. s_data may be X when s_valid=0.
//  - R==1 degenerates to a single-entry register slice with s_ready=!full||m_ready.
// TESTING (WORD_W=8, S_WORDS=4, M_WORDS=1 unless stated)
//  1 Reset: hold rstn=0 for 3 cycles with s_valid=1 -> m_valid=0, s_ready=0 throughout,
//    and no output transfer after release until an input handshake.
//  2 Single beat: send s_data={8'h44,8'h33,8'h22,8'h11} with m_ready=1
//    -> m_data 11,22,33,44 on 4 consecutive cycles starting 1 cycle after accept.
//    s_ready=0 during sub-beats 0-2 and 1 on the cycle of sub-beat 3.
//  3 Back-to-back: 10 input beats, s_valid=1 and m_ready=1 constant -> 40 output
//    transfers in 40 consecutive cycles, no bubbles, word order preserved.
//  4 Backpressure: 20% random m_ready, 20% random s_valid with X data when invalid,
//    50 beats -> scoreboard matches all 200 words in order. m_data is stable under stall,
//    and X never appears on a handshake.
//  5 Reset mid-beat: reset after 2 sub-beats are sent -> remaining 2 words are never
//    emitted, and the next beat starts from its word 0.
//  6 Params S_WORDS=4, M_WORDS=2, and S_WORDS=M_WORDS=2 (R=1): repeat test 3.
//    Expect pairs {11,22},{33,44} for the first, and pass-through at 1 beat/cycle
//    for the second.

Source files
------------

// File: rtl/axis_width_downsizer.sv
`default_nettype none
// ============================================================================
//  Module   : axis_width_downsizer
//  Purpose  : AXI-Stream width downsizer. Takes one wide beat of S_WORDS words
//             and emits it as R = S_WORDS/M_WORDS narrow beats of M_WORDS
//             words each, starting with the lowest-indexed words. Runs at one
//             narrow beat per cycle with no bubbles between wide beats.
//  Ports    : clk      - clock, all state updates on posedge
//             rstn     - synchronous active-low reset
//             s_valid  - wide input beat valid
//             s_ready  - downsizer can take a wide beat
//             s_data   - wide input beat, word i = s_data[i]
//             m_valid  - narrow output beat valid
//             m_ready  - downstream takes the narrow beat
//             m_data   - narrow output beat
//  Params   : WORD_W   - bits per word
//             S_WORDS  - words per input beat (integer multiple of M_WORDS)
//             M_WORDS  - words per output beat
//  Revision : 1.0  initial release
// ============================================================================
module axis_width_downsizer #(
  parameter int WORD_W  = 8,
  parameter int S_WORDS = 4,
  parameter int M_WORDS = 1
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic [S_WORDS-1:0][WORD_W-1:0]   s_data,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [M_WORDS-1:0][WORD_W-1:0]   m_data
);

  localparam int R     = S_WORDS / M_WORDS;
  localparam int CNT_W = (R > 1) ? $clog2(R) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(R - 1);

  logic [S_WORDS-1:0][WORD_W-1:0] r_buf;
  logic                           r_full;
  logic [CNT_W-1:0]               r_cnt;

  logic w_last;
  logic w_in_hs;
  logic w_out_hs;

  assign w_last = (r_cnt == C_LAST);

  // A new wide beat may enter while the last sub-beat of the current one is
  // leaving; this m_ready -> s_ready path is what removes the bubble.
  assign s_ready = rstn && (!r_full || (m_ready && w_last));

  // Gated with rstn so outputs are quiet for the whole reset window, including
  // the cycle before the first reset edge has cleared r_full.
  assign m_valid = rstn && r_full;

  assign w_in_hs  = s_valid && s_ready;
  assign w_out_hs = m_valid && m_ready;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_full <= 1'b0;
      r_cnt  <= '0;
    end else if (w_in_hs) begin
      // Covers both an empty buffer and the overlap with the last sub-beat.
      r_full <= 1'b1;
      r_cnt  <= '0;
    end else if (w_out_hs) begin
      if (w_last) begin
        r_full <= 1'b0;
        r_cnt  <= '0;
      end else begin
        r_cnt  <= r_cnt + 1'b1;
      end
    end
  end

  // Payload has no reset: its contents are ignored while r_full is low.
  // w_in_hs already includes rstn through s_ready.
  always_ff @(posedge clk) begin
    if (w_in_hs) begin
      r_buf <= s_data;
    end
  end

  generate
    if (R == 1) begin : g_single
      // One sub-beat per wide beat: plain register slice.
      assign m_data = r_buf;
    end else begin : g_multi
      always_comb begin
        m_data = r_buf[M_WORDS-1:0];
        for (int i = 1; i < R; i++) begin
          if (r_cnt == CNT_W'(i)) begin
            m_data = r_buf[i*M_WORDS +: M_WORDS];
          end
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_axis_width_downsizer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axis_width_downsizer
//  Purpose  : Self-checking bench for axis_width_downsizer. Three instances:
//             A (8b words, 4 -> 1), B (4 -> 2) and C (2 -> 2, register slice).
//             A word-queue reference model predicts valid/ready/data.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_axis_width_downsizer;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  // Instance A : S_WORDS=4, M_WORDS=1
  logic            a_s_valid = 1'b0;
  logic            a_s_ready;
  logic [3:0][7:0] a_s_data  = '0;
  logic            a_m_valid;
  logic            a_m_ready = 1'b0;
  logic [0:0][7:0] a_m_data;

  // Instance B : S_WORDS=4, M_WORDS=2
  logic            b_s_valid = 1'b0;
  logic            b_s_ready;
  logic [3:0][7:0] b_s_data  = '0;
  logic            b_m_valid;
  logic            b_m_ready = 1'b0;
  logic [1:0][7:0] b_m_data;

  // Instance C : S_WORDS=2, M_WORDS=2
  logic            c_s_valid = 1'b0;
  logic            c_s_ready;
  logic [1:0][7:0] c_s_data  = '0;
  logic            c_m_valid;
  logic            c_m_ready = 1'b0;
  logic [1:0][7:0] c_m_data;

  axis_width_downsizer #(.WORD_W(8), .S_WORDS(4), .M_WORDS(1)) u_a (
    .clk(clk), .rstn(rstn),
    .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(a_s_data),
    .m_valid(a_m_valid), .m_ready(a_m_ready), .m_data(a_m_data)
  );

  axis_width_downsizer #(.WORD_W(8), .S_WORDS(4), .M_WORDS(2)) u_b (
    .clk(clk), .rstn(rstn),
    .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data),
    .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data)
  );

  axis_width_downsizer #(.WORD_W(8), .S_WORDS(2), .M_WORDS(2)) u_c (
    .clk(clk), .rstn(rstn),
    .s_valid(c_s_valid), .s_ready(c_s_ready), .s_data(c_s_data),
    .m_valid(c_m_valid), .m_ready(c_m_ready), .m_data(c_m_data)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: words accepted but not yet emitted, oldest first.
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [7:0] qc[$];

  int cyc = 0;
  int a_in = 0, a_out = 0, a_first = -1, a_last = -1, a_in_cyc = -1;
  int b_in = 0, b_out = 0, b_first = -1, b_last = -1;
  int c_in = 0, c_out = 0, c_first = -1, c_last = -1;
  logic       a_stall = 1'b0;
  logic [7:0] a_prev  = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of instance A: drive, check at negedge, advance model.
  task automatic a_cycle(input logic rs, input logic sv, input logic [31:0] sd, input logic mr);
    logic [7:0] e;
    logic hs_out, hs_in;
    rstn = rs; a_s_valid = sv; a_s_data = sd; a_m_ready = mr;
    @(negedge clk);
    chk("a_m_valid", 64'(a_m_valid), 64'(rs && qa.size() != 0));
    chk("a_s_ready", 64'(a_s_ready), 64'(rs && (qa.size() == 0 || (mr && qa.size() == 1))));
    if (a_stall && a_m_valid) chk("a_stall_hold", 64'(a_m_data), 64'(a_prev));
    hs_out = a_m_valid && mr;
    hs_in  = sv && a_s_ready;
    if (hs_out === 1'b1) begin
      if (qa.size() > 0) begin
        e = qa.pop_front();
        chk("a_m_data", 64'(a_m_data), 64'(e));
      end
      a_out++;
      if (a_first < 0) a_first = cyc;
      a_last = cyc;
    end
    if (!rs) begin
      qa.delete();
      a_stall = 1'b0;
    end else begin
      if (hs_in === 1'b1) begin
        for (int k = 0; k < 4; k++) qa.push_back(sd[8*k +: 8]);
        a_in++;
        a_in_cyc = cyc;
      end
      a_stall = a_m_valid && !mr;
    end
    a_prev = a_m_data;
    cyc++;
    @(posedge clk); #1;
  endtask

  // One clock of instances B and C together, both sinks always ready.
  task automatic bc_cycle(input logic bsv, input logic [31:0] bsd,
                          input logic csv, input logic [15:0] csd);
    logic [15:0] e;
    b_s_valid = bsv; b_s_data = bsd; b_m_ready = 1'b1;
    c_s_valid = csv; c_s_data = csd; c_m_ready = 1'b1;
    @(negedge clk);
    chk("b_m_valid", 64'(b_m_valid), 64'(qb.size() != 0));
    chk("b_s_ready", 64'(b_s_ready), 64'(qb.size() == 0 || qb.size() == 2));
    chk("c_m_valid", 64'(c_m_valid), 64'(qc.size() != 0));
    chk("c_s_ready", 64'(c_s_ready), 64'(qc.size() == 0 || qc.size() == 2));
    if (b_m_valid === 1'b1) begin
      if (qb.size() >= 2) begin
        e = {qb[1], qb[0]};
        void'(qb.pop_front());
        void'(qb.pop_front());
        chk("b_m_data", 64'(b_m_data), 64'(e));
      end
      b_out++;
      if (b_first < 0) b_first = cyc;
      b_last = cyc;
    end
    if (c_m_valid === 1'b1) begin
      if (qc.size() >= 2) begin
        e = {qc[1], qc[0]};
        void'(qc.pop_front());
        void'(qc.pop_front());
        chk("c_m_data", 64'(c_m_data), 64'(e));
      end
      c_out++;
      if (c_first < 0) c_first = cyc;
      c_last = cyc;
    end
    if ((bsv && b_s_ready) === 1'b1) begin
      for (int k = 0; k < 4; k++) qb.push_back(bsd[8*k +: 8]);
      b_in++;
    end
    if ((csv && c_s_ready) === 1'b1) begin
      for (int k = 0; k < 2; k++) qc.push_back(csd[8*k +: 8]);
      c_in++;
    end
    cyc++;
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        sv;
    logic [31:0] d;
    int          snap;

    // Reset held with s_valid high, then idle: nothing may come out.
    repeat (3) a_cycle(1'b0, 1'b1, $urandom, 1'b0);
    repeat (3) a_cycle(1'b1, 1'b0, 'x, 1'b1);
    chk("t1_no_output", 64'(a_out), 64'd0);

    // Single beat, sink always ready.
    a_cycle(1'b1, 1'b1, 32'h44332211, 1'b1);
    repeat (5) a_cycle(1'b1, 1'b0, 'x, 1'b1);
    chk("t2_count", 64'(a_out), 64'd4);
    chk("t2_latency", 64'(a_first - a_in_cyc), 64'd1);
    chk("t2_span", 64'(a_last - a_first + 1), 64'd4);

    // Ten beats back to back, no bubbles.
    a_in = 0; a_out = 0; a_first = -1;
    for (int i = 0; i < 60 && a_out < 40; i++) begin
      d = (a_in == 0) ? 32'h44332211 : $urandom;
      a_cycle(1'b1, a_in < 10, d, 1'b1);
    end
    chk("t3_count", 64'(a_out), 64'd40);
    chk("t3_span", 64'(a_last - a_first + 1), 64'd40);

    // Random backpressure and sparse source with X payload when idle.
    a_in = 0; a_out = 0; a_first = -1;
    for (int i = 0; i < 8000 && a_out < 200; i++) begin
      sv = (a_in < 50) && ($urandom_range(0, 4) == 0);
      d  = sv ? $urandom : 'x;
      a_cycle(1'b1, sv, d, $urandom_range(0, 4) == 0);
    end
    chk("t4_count", 64'(a_out), 64'd200);
    chk("t4_drained", 64'(qa.size()), 64'd0);

    // Reset after two sub-beats: the rest of the beat is dropped.
    a_cycle(1'b1, 1'b1, 32'hDDCCBBAA, 1'b0);
    a_cycle(1'b1, 1'b0, 'x, 1'b1);
    a_cycle(1'b1, 1'b0, 'x, 1'b1);
    a_cycle(1'b1, 1'b0, 'x, 1'b0);
    snap = a_out;
    repeat (2) a_cycle(1'b0, 1'b1, $urandom, 1'b1);
    repeat (3) a_cycle(1'b1, 1'b0, 'x, 1'b1);
    chk("t5_no_stale", 64'(a_out), 64'(snap));
    a_cycle(1'b1, 1'b1, 32'h87654321, 1'b1);
    repeat (5) a_cycle(1'b1, 1'b0, 'x, 1'b1);
    chk("t5_new_beat", 64'(a_out), 64'(snap + 4));

    // 4 -> 2 and 2 -> 2 back to back.
    for (int i = 0; i < 60 && (b_out < 20 || c_out < 10); i++) begin
      bc_cycle(b_in < 10, (b_in == 0) ? 32'h44332211 : 32'($urandom),
               c_in < 10, (c_in == 0) ? 16'h2211 : 16'($urandom));
    end
    chk("t6_b_count", 64'(b_out), 64'd20);
    chk("t6_b_span", 64'(b_last - b_first + 1), 64'd20);
    chk("t6_c_count", 64'(c_out), 64'd10);
    chk("t6_c_span", 64'(c_last - c_first + 1), 64'd10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
